// File: rtl/ei_spi_pkg.sv
// Shared types and defaults for the SPI slave core: FSM states, SPI mode encoding
// and the idle-word defaults.
`ifndef NO_OF_SLAVE
`define NO_OF_SLAVE 4
`endif

package ei_spi_pkg;

  localparam int         DEFAULT_DATA_WIDTH = 8;
  localparam logic [7:0] DEFAULT_IDLE_TX    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_e;

  // Encoded as {CPOL, CPHA}
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  function automatic spi_mode_e spi_mode(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

endpackage

// File: rtl/ei_spi_sync.sv
// Two-flop synchronizer for one asynchronous bus line, followed by an edge-detect
// register that yields single-cycle rise/fall pulses.
module ei_spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ei_spi_slave_core.sv
// SPI slave core: oversamples SS_/SCLK/MOSI on CLK, deserializes MOSI into rx words
// and serializes a one-entry tx holding register onto a tri-stated MISO.
`ifndef NO_OF_SLAVE
`define NO_OF_SLAVE 4
`endif

module ei_spi_slave_core
  import ei_spi_pkg::*;
#(
  parameter int                    NO_OF_SLAVE = `NO_OF_SLAVE,
  parameter int                    SLAVE_ID    = 0,
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter logic                  CPOL        = 1'b0,
  parameter logic                  CPHA        = 1'b0,
  parameter logic [DATA_WIDTH-1:0] IDLE_TX     = DATA_WIDTH'(DEFAULT_IDLE_TX)
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic [NO_OF_SLAVE-1:0] SS_,
  input  logic                   SCLK,
  input  logic                   MOSI,
  output logic                   MISO,
  input  logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [DATA_WIDTH-1:0]  rx_data,
  output logic                   rx_valid,
  output logic                   tx_underrun,
  output logic                   busy
);

  localparam int         CNT_W     = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam spi_mode_e  MODE      = spi_mode(CPOL, CPHA);
  localparam logic [1:0] MODE_BITS = MODE;
  localparam logic       IDLE_HIGH   = MODE_BITS[1];
  localparam logic       LATE_SAMPLE = MODE_BITS[0];

  logic ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  ei_spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .clk_i (CLK), .rst_ni (RESETn), .d_i (SS_[SLAVE_ID]),
    .q_o (ss_s), .rise_o (ss_rise), .fall_o (ss_fall)
  );

  ei_spi_sync #(.RST_VAL(CPOL)) u_sync_sclk (
    .clk_i (CLK), .rst_ni (RESETn), .d_i (SCLK),
    .q_o (sclk_s), .rise_o (sclk_rise), .fall_o (sclk_fall)
  );

  ei_spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i (CLK), .rst_ni (RESETn), .d_i (MOSI),
    .q_o (mosi_s), .rise_o (mosi_rise), .fall_o (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{ss_s, sclk_s, mosi_rise, mosi_fall, SS_};

  logic leading_edge, trailing_edge, sample_edge, shift_edge;
  assign leading_edge  = IDLE_HIGH ? sclk_fall : sclk_rise;
  assign trailing_edge = IDLE_HIGH ? sclk_rise : sclk_fall;
  assign sample_edge   = LATE_SAMPLE ? trailing_edge : leading_edge;
  assign shift_edge    = LATE_SAMPLE ? leading_edge : trailing_edge;

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  skip_q, skip_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  load_now, tx_accept;
  logic [DATA_WIDTH-1:0] rx_word;

  assign tx_accept = tx_valid && !hold_full_q;
  assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      skip_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_valid_q  <= rx_valid_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    skip_d      = skip_q;
    cnt_d       = cnt_q;
    rx_valid_d  = 1'b0;
    load_now    = 1'b0;

    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_fall) state_d = LOAD;
        end
        LOAD: begin
          load_now = 1'b1;
          // With a late sample the first leading edge only presents the MSB
          skip_d   = LATE_SAMPLE;
          state_d  = SHIFT;
        end
        SHIFT: begin
          if (sample_edge) begin
            rx_shift_d = rx_word;
            if (cnt_q == LAST_BIT) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
              load_now   = 1'b1;
              // The next shift edge belongs to the word just finished, keep the new MSB
              skip_d     = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (shift_edge) begin
            if (skip_q) skip_d = 1'b0;
            else        tx_shift_d = tx_shift_q << 1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load_now) begin
      tx_shift_d  = hold_full_q ? hold_q : IDLE_TX;
      hold_full_d = 1'b0;
      cnt_d       = '0;
    end
    if (tx_accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  assign MISO        = (RESETn && !SS_[SLAVE_ID] && state_q != IDLE) ? tx_shift_q[DATA_WIDTH-1] : 1'bz;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = load_now & ~hold_full_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ei_spi_slave_core.sv
// Self-checking bench: a behavioural SPI master drives two slave instances (mode 0 and
// mode 3) and compares captured MISO words, rx words, pulse counts and latency to a model.
`timescale 1ns/1ps
module tb_ei_spi_slave_core;

  localparam int         NS   = 4;
  localparam int         DW   = 8;
  localparam logic [7:0] IDLE = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] ss_n = '1;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;

  logic [DW-1:0] tx_data0 = '0, tx_data3 = '0;
  logic          tx_valid0 = 1'b0, tx_valid3 = 1'b0;
  logic          tx_ready0, tx_ready3;
  logic [DW-1:0] rx_data0, rx_data3;
  logic          rx_valid0, rx_valid3;
  logic          underrun0, underrun3;
  logic          busy0, busy3;
  wire           miso0, miso3;
  wire           miso0_z = (miso0 === 1'bz);
  wire           miso3_z = (miso3 === 1'bz);

  always #5 clk = ~clk;

  ei_spi_slave_core #(
    .NO_OF_SLAVE (NS), .SLAVE_ID (0), .DATA_WIDTH (DW),
    .CPOL (1'b0), .CPHA (1'b0), .IDLE_TX (IDLE)
  ) u_dut0 (
    .CLK (clk), .RESETn (rst_n), .SS_ (ss_n), .SCLK (sclk), .MOSI (mosi), .MISO (miso0),
    .tx_data (tx_data0), .tx_valid (tx_valid0), .tx_ready (tx_ready0),
    .rx_data (rx_data0), .rx_valid (rx_valid0), .tx_underrun (underrun0), .busy (busy0)
  );

  ei_spi_slave_core #(
    .NO_OF_SLAVE (NS), .SLAVE_ID (2), .DATA_WIDTH (DW),
    .CPOL (1'b1), .CPHA (1'b1), .IDLE_TX (IDLE)
  ) u_dut3 (
    .CLK (clk), .RESETn (rst_n), .SS_ (ss_n), .SCLK (sclk), .MOSI (mosi), .MISO (miso3),
    .tx_data (tx_data3), .tx_valid (tx_valid3), .tx_ready (tx_ready3),
    .rx_data (rx_data3), .rx_valid (rx_valid3), .tx_underrun (underrun3), .busy (busy3)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_edge_cyc = 0;
  int rxv_cyc0 = 0, rxv_cyc3 = 0;
  int un0 = 0, un3 = 0;
  logic [7:0] rxq0[$];
  logic [7:0] rxq3[$];
  logic [7:0] mo_w[4];
  logic [7:0] tx_w[4];
  logic [7:0] mi_w[4];
  logic [7:0] last_rx0 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid0) begin rxq0.push_back(rx_data0); rxv_cyc0 = cyc; end
    if (rx_valid3) begin rxq3.push_back(rx_data3); rxv_cyc3 = cyc; end
    if (underrun0) un0++;
    if (underrun3) un3++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic miso_of(input int which);
    return (which == 0) ? miso0 : miso3;
  endfunction

  function automatic logic rdy(input int which);
    return (which == 0) ? tx_ready0 : tx_ready3;
  endfunction

  function automatic int rxq_size(input int which);
    return (which == 0) ? rxq0.size() : rxq3.size();
  endfunction

  function automatic logic [7:0] rxq_at(input int which, input int idx);
    return (which == 0) ? rxq0[idx] : rxq3[idx];
  endfunction

  task automatic push_tx(input int which, input logic [7:0] w, input string tag);
    chk($sformatf("%s/tx_ready_before_push", tag), 32'(rdy(which)), 32'd1);
    if (which == 0) begin tx_data0 = w; tx_valid0 = 1'b1; end
    else            begin tx_data3 = w; tx_valid3 = 1'b1; end
    step();
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
  endtask

  // Pushes tx_w[1..nf-1] as soon as the holding register frees up
  task automatic feeder(input int which, input int nf, input string tag);
    for (int k = 1; k < nf; k++) begin
      int t;
      t = 0;
      while (!rdy(which) && t < 600) begin step(); t++; end
      push_tx(which, tx_w[k], tag);
    end
  endtask

  // Master: nw words, last word truncated to nbits_last bits; which=0 mode 0, which=1 mode 3
  task automatic master_frame(input int which, input int nw, input int nbits_last, input bit release_ss);
    bit cpol, cpha;
    int nb;
    cpol = (which != 0);
    cpha = (which != 0);
    ss_n[(which == 0) ? 0 : 2] = 1'b0;
    repeat (6) step();
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? nbits_last : 8;
      for (int b = 0; b < nb; b++) begin
        int i;
        i = 7 - b;
        if (!cpha) begin
          mosi = mo_w[w][i];
          repeat (4) step();
          mi_w[w][i] = miso_of(which);
          sclk = ~cpol;
          if (w == nw - 1 && b == 7) last_edge_cyc = cyc;
          repeat (4) step();
          sclk = cpol;
        end else begin
          sclk = ~cpol;
          mosi = mo_w[w][i];
          repeat (4) step();
          mi_w[w][i] = miso_of(which);
          sclk = cpol;
          if (w == nw - 1 && b == 7) last_edge_cyc = cyc;
          repeat (4) step();
        end
      end
    end
    repeat (4) step();
    if (release_ss) ss_n = '1;
  endtask

  // One full frame plus checks against the model: each word start loads the next
  // pushed word or IDLE (with an underrun), including the load after the last word.
  task automatic do_frame(input int which, input int nw, input int nf, input string tag);
    int un_base;
    logic [7:0] exp_w;
    rxq0.delete();
    rxq3.delete();
    un_base = (which == 0) ? un0 : un3;
    if (nf > 0) push_tx(which, tx_w[0], tag);
    fork
      master_frame(which, nw, 8, 1'b1);
      feeder(which, nf, tag);
    join
    repeat (6) step();
    for (int w = 0; w < nw; w++) begin
      exp_w = (w < nf) ? tx_w[w] : IDLE;
      chk($sformatf("%s/miso_word%0d", tag, w), 32'(mi_w[w]), 32'(exp_w));
    end
    chk($sformatf("%s/rx_count", tag), 32'(rxq_size(which)), 32'(nw));
    for (int w = 0; w < nw && w < rxq_size(which); w++)
      chk($sformatf("%s/rx_word%0d", tag, w), 32'(rxq_at(which, w)), 32'(mo_w[w]));
    chk($sformatf("%s/underruns", tag), 32'(((which == 0) ? un0 : un3) - un_base), 32'(nw + 1 - nf));
    chk($sformatf("%s/rx_latency", tag), 32'(((which == 0) ? rxv_cyc0 : rxv_cyc3) - last_edge_cyc), 32'd3);
    chk($sformatf("%s/busy_after", tag), 32'((which == 0) ? busy0 : busy3), 32'd0);
    chk($sformatf("%s/tx_ready_after", tag), 32'(rdy(which)), 32'd1);
    if (which == 0) last_rx0 = mo_w[nw - 1];
  endtask

  initial begin
    int nw, nf, un_base;

    // Reset values
    repeat (4) step();
    chk("rst/tx_ready", 32'(tx_ready0), 32'd1);
    chk("rst/rx_data", 32'(rx_data0), 32'd0);
    chk("rst/rx_valid", 32'(rx_valid0), 32'd0);
    chk("rst/underrun", 32'(underrun0), 32'd0);
    chk("rst/busy", 32'(busy0), 32'd0);
    chk("rst/miso_z", 32'(miso0_z), 32'd1);
    rst_n = 1'b1;
    repeat (4) step();

    // Mode 0 single word
    tx_w[0] = 8'hA5; mo_w[0] = 8'h3C;
    do_frame(0, 1, 1, "single");
    chk("single/rx_data_pin", 32'(rx_data0), 32'h3C);

    // Back-to-back words, a third word keeps the trailing load fed
    tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33;
    mo_w[0] = 8'hF0; mo_w[1] = 8'h0F;
    do_frame(0, 2, 3, "b2b");

    // Empty holding register
    mo_w[0] = 8'($urandom);
    do_frame(0, 1, 0, "empty");

    // Partial word, then SS_ release
    rxq0.delete();
    un_base = un0;
    mo_w[0] = 8'h6B;
    master_frame(0, 1, 5, 1'b0);
    chk("partial/busy_before", 32'(busy0), 32'd1);
    chk("partial/miso_driven", 32'(miso0_z), 32'd0);
    ss_n = '1;
    #1;
    chk("partial/miso_z_same_cycle", 32'(miso0_z), 32'd1);
    repeat (6) step();
    chk("partial/rx_count", 32'(rxq0.size()), 32'd0);
    chk("partial/rx_data_kept", 32'(rx_data0), 32'(last_rx0));
    chk("partial/busy_after", 32'(busy0), 32'd0);
    chk("partial/underruns", 32'(un0 - un_base), 32'd1);
    mo_w[0] = 8'h81;
    do_frame(0, 1, 0, "after_partial");

    // Another slave selected: this one must stay silent
    rxq0.delete();
    un_base = un0;
    ss_n = 4'b1101;
    for (int k = 0; k < 20; k++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      repeat (4) step();
      chk($sformatf("desel%0d/miso_z", k), 32'(miso0_z), 32'd1);
      chk($sformatf("desel%0d/busy", k), 32'(busy0), 32'd0);
    end
    ss_n = '1;
    sclk = 1'b0;
    repeat (4) step();
    chk("desel/rx_count", 32'(rxq0.size()), 32'd0);
    chk("desel/underruns", 32'(un0 - un_base), 32'd0);

    // Randomized mode-0 frames
    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(1, 3);
      nf = $urandom_range(0, nw + 1);
      for (int k = 0; k < 4; k++) begin
        tx_w[k] = 8'($urandom);
        mo_w[k] = 8'($urandom);
      end
      do_frame(0, nw, nf, $sformatf("rand%0d", r));
    end

    // Mode 3 slave
    sclk = 1'b1;
    repeat (4) step();
    tx_w[0] = 8'hC3; mo_w[0] = 8'h5A;
    do_frame(1, 1, 1, "mode3");
    chk("mode3/rx_data_pin", 32'(rx_data3), 32'h5A);
    for (int k = 0; k < 4; k++) begin
      tx_w[k] = 8'($urandom);
      mo_w[k] = 8'($urandom);
    end
    do_frame(1, 2, $urandom_range(0, 3), "mode3_rand");

    // Reset in the middle of a word, with the holding register occupied
    tx_w[0] = 8'h96; tx_w[1] = 8'h4D; mo_w[0] = 8'hE7;
    push_tx(1, tx_w[0], "rstmid");
    fork
      master_frame(1, 1, 5, 1'b0);
      feeder(1, 2, "rstmid");
    join
    chk("rstmid/tx_ready_before", 32'(tx_ready3), 32'd0);
    chk("rstmid/busy_before", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rstmid/tx_ready", 32'(tx_ready3), 32'd1);
    chk("rstmid/busy", 32'(busy3), 32'd0);
    chk("rstmid/miso_z", 32'(miso3_z), 32'd1);
    chk("rstmid/rx_data", 32'(rx_data3), 32'd0);
    chk("rstmid/rx_valid", 32'(rx_valid3), 32'd0);
    chk("rstmid/underrun", 32'(underrun3), 32'd0);
    ss_n = '1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
